// File: rtl/sbit_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// sbit_frame_tx_pkg
// Shared definitions for the S-bit frame transmitter:
//   - default frame size and SoT offset
//   - transmitter state encoding
//   - PRBS-7 (x^7 + x^6 + 1) seed and single-step helper, used when the
//     design is built with SBIT_TX_PRBS_EN defined.
// -----------------------------------------------------------------------------
package sbit_frame_tx_pkg;

  // Bits per frame per lane. Eight lanes make up the full S-bit word.
  localparam int FRAME_SIZE_DEF = 8;

  // Added to the slip to form the SoT bit index. The value 7 matches the
  // receive aligner map "SoT bit k -> bitslip count k+1", so the receiver
  // recovers a bitslip count equal to the transmit slip.
  localparam int SOT_OFFSET_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESLIP = 2'd3
  } tx_state_e;

  // PRBS-7, polynomial x^7 + x^6 + 1, Fibonacci form.
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // One PRBS-7 step: the new bit is shifted in at bit 0 and is also the
  // emitted output bit.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage : sbit_frame_tx_pkg

// File: rtl/sbit_frame_tx_if.sv
// -----------------------------------------------------------------------------
// sbit_frame_tx_if
// S-bit data bus of the frame transmitter.
//   sbits_i           S-bits offered to the transmitter (lane I = bits
//                     FRAME_SIZE*(I+1)-1 : FRAME_SIZE*I)
//   sbits_o           framed, phase-shifted S-bits
//   start_of_frame_o  one-hot SoT word, aligned with sbits_o
// Modports:
//   master  source of sbits_i and sink of the framed output
//   slave   the transmitter itself
// -----------------------------------------------------------------------------
interface sbit_frame_tx_if #(
  parameter int FRAME_SIZE = 8
);
  localparam int MXSBITS = 8 * FRAME_SIZE;

  logic [MXSBITS-1:0]    sbits_i;
  logic [MXSBITS-1:0]    sbits_o;
  logic [FRAME_SIZE-1:0] start_of_frame_o;

  modport master (
    output sbits_i,
    input  sbits_o,
    input  start_of_frame_o
  );

  modport slave (
    input  sbits_i,
    output sbits_o,
    output start_of_frame_o
  );

endinterface : sbit_frame_tx_if

// File: rtl/sbit_frame_tx_slip.sv
// -----------------------------------------------------------------------------
// frame_slip_tx
// One lane of the transmitter: keeps the previous input frame and emits a
// registered window of {din, prev} selected by the slip.
//   clock    fabric clock
//   reset_i  synchronous, active-high reset
//   slip_i   bit phase to apply, 0..FRAME_SIZE-1
//   pass_i   1 = load the shifted frame, 0 = load zero
//   din_i    input frame for this lane
//   dout_o   registered output frame
// Slip 0 gives dout = din delayed by one cycle.
// -----------------------------------------------------------------------------
module frame_slip_tx #(
  parameter int FRAME_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset_i,
  input  logic [2:0]            slip_i,
  input  logic                  pass_i,
  input  logic [FRAME_SIZE-1:0] din_i,
  output logic [FRAME_SIZE-1:0] dout_o
);

  logic [FRAME_SIZE-1:0]   prev;
  logic [2*FRAME_SIZE-1:0] window;
  logic [2*FRAME_SIZE-1:0] shifted;

  // Shifting right by (FRAME_SIZE - slip) takes the top `slip` bits of prev
  // into the low end of the output and the low bits of din above them.
  always_comb begin
    window  = {din_i, prev};
    shifted = window >> (FRAME_SIZE - int'(slip_i));
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // the design samples the pre-edge values, independent of process order.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      prev   <= '0;
      dout_o <= '0;
    end else begin
      // History is kept in every state so the first RUN word is correct.
      prev   <= din_i;
      dout_o <= pass_i ? shifted[FRAME_SIZE-1:0] : '0;
    end
  end

endmodule : frame_slip_tx

// File: rtl/sbit_frame_tx.sv
// -----------------------------------------------------------------------------
// sbit_frame_tx
// Transmit-side counterpart of the trigger-link frame aligner. Emits 64 S-bits
// per clock as 8 lanes of FRAME_SIZE-bit frames with a programmable bit phase,
// plus a one-hot start-of-frame (SoT) word. Runs IDLE -> TRAIN -> RUN, with a
// one-cycle RESLIP whenever the requested slip changes, and can blank the SoT
// for single cycles to exercise the receiver's error handling.
//
// Ports:
//   clock             40 MHz fabric clock
//   reset_i           synchronous, active-high reset
//   enable_i          transmitter enable; low forces IDLE
//   slip_i            requested bit phase (taken mod FRAME_SIZE)
//   train_cycles_i    TRAIN length; 0 means a single TRAIN cycle
//   inject_sot_err_i  blanks SoT for one output cycle when in RUN
//   prbs_sel_i        select internal PRBS-7 data (SBIT_TX_PRBS_EN only)
//   bus               S-bit data bus (sbits_i, sbits_o, start_of_frame_o)
//   running_o         high in RUN
//   slip_active_o     slip currently applied
//   sot_err_cnt_o     saturating count of injected SoT errors
//
// Build option: define SBIT_TX_PRBS_EN to add a PRBS-7 source selectable by
// prbs_sel_i. Without it prbs_sel_i is ignored.
// -----------------------------------------------------------------------------
module sbit_frame_tx
  import sbit_frame_tx_pkg::*;
#(
  parameter int FRAME_SIZE = FRAME_SIZE_DEF,
  parameter int SOT_OFFSET = SOT_OFFSET_DEF
) (
  input  logic                 clock,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [2:0]           slip_i,
  input  logic [11:0]          train_cycles_i,
  input  logic                 inject_sot_err_i,
  input  logic                 prbs_sel_i,
  sbit_frame_tx_if.slave       bus,
  output logic                 running_o,
  output logic [2:0]           slip_active_o,
  output logic [15:0]          sot_err_cnt_o
);

  localparam int MXSBITS = 8 * FRAME_SIZE;

  tx_state_e             state;
  tx_state_e             next_state;
  logic [2:0]            slip_req;
  logic [2:0]            slip_next;
  logic [11:0]           train_cnt;
  logic [11:0]           train_cnt_next;
  logic                  inject_hit;
  logic [FRAME_SIZE-1:0] sof_next;
  logic [FRAME_SIZE-1:0] sof_q;
  logic                  pass_data;
  logic [MXSBITS-1:0]    din_word;
  logic [MXSBITS-1:0]    dout_word;

  // One-hot SoT for a given slip.
  function automatic logic [FRAME_SIZE-1:0] sot_word(input logic [2:0] slip);
    return FRAME_SIZE'(1) << ((int'(slip) + SOT_OFFSET) % FRAME_SIZE);
  endfunction

  // Out-of-range slips fold back into 0..FRAME_SIZE-1.
  assign slip_req = 3'(int'(slip_i) % FRAME_SIZE);

  // ---------------------------------------------------------------------------
  // FSM next state. Priority: enable low > slip change > inject.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state     = state;
    slip_next      = slip_active_o;
    train_cnt_next = train_cnt;
    inject_hit     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable_i) begin
          next_state     = ST_TRAIN;
          slip_next      = slip_req;
          train_cnt_next = '0;
        end
      end
      ST_TRAIN: begin
        if (!enable_i) begin
          next_state = ST_IDLE;
        end else if (slip_req != slip_active_o) begin
          next_state = ST_RESLIP;
        end else if (train_cnt == train_cycles_i) begin
          next_state = ST_RUN;
        end else begin
          train_cnt_next = train_cnt + 12'd1;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          next_state = ST_IDLE;
        end else if (slip_req != slip_active_o) begin
          next_state = ST_RESLIP;
        end else begin
          inject_hit = inject_sot_err_i;
        end
      end
      ST_RESLIP: begin
        if (!enable_i) begin
          next_state = ST_IDLE;
        end else begin
          next_state     = ST_TRAIN;
          slip_next      = slip_req;
          train_cnt_next = '0;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // Leaving for IDLE clears the applied slip and the train counter.
    if (next_state == ST_IDLE) begin
      slip_next      = '0;
      train_cnt_next = '0;
    end
  end

  // SoT and data are loaded for the state being entered, so the output
  // registers line up with the state register.
  always_comb begin
    sof_next = '0;
    case (next_state)
      ST_TRAIN: sof_next = sot_word(slip_next);
      ST_RUN:   sof_next = inject_hit ? '0 : sot_word(slip_next);
      default:  sof_next = '0;
    endcase
  end

  assign pass_data = (next_state == ST_RUN);

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      slip_active_o <= '0;
      train_cnt     <= '0;
      running_o     <= 1'b0;
      sof_q         <= '0;
      sot_err_cnt_o <= '0;
    end else begin
      state         <= next_state;
      slip_active_o <= slip_next;
      train_cnt     <= train_cnt_next;
      running_o     <= (next_state == ST_RUN);
      sof_q         <= sof_next;
      if (inject_hit && (sot_err_cnt_o != 16'hFFFF)) begin
        sot_err_cnt_o <= sot_err_cnt_o + 16'd1;
      end
    end
  end

  assign bus.start_of_frame_o = sof_q;

  // ---------------------------------------------------------------------------
  // Data source.
  // ---------------------------------------------------------------------------
`ifdef SBIT_TX_PRBS_EN
  logic [6:0]         lfsr;
  logic [6:0]         lfsr_adv;
  logic [MXSBITS-1:0] prbs_word;

  // Bit i of the word is the i-th bit produced from the current LFSR state.
  always_comb begin
    lfsr_adv  = lfsr;
    prbs_word = '0;
    for (int i = 0; i < MXSBITS; i++) begin
      lfsr_adv     = prbs7_step(lfsr_adv);
      prbs_word[i] = lfsr_adv[0];
    end
  end

  // Advances once for every word that is emitted in RUN, holds otherwise.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      lfsr <= PRBS7_SEED;
    end else if (next_state == ST_RUN) begin
      lfsr <= lfsr_adv;
    end
  end

  assign din_word = prbs_sel_i ? prbs_word : bus.sbits_i;
`else
  logic prbs_sel_unused;
  assign prbs_sel_unused = prbs_sel_i;
  assign din_word        = bus.sbits_i;
`endif

  // ---------------------------------------------------------------------------
  // Eight lanes sharing one slip.
  // ---------------------------------------------------------------------------
  for (genvar lane = 0; lane < 8; lane++) begin : g_lane
    frame_slip_tx #(
      .FRAME_SIZE (FRAME_SIZE)
    ) u_lane (
      .clock   (clock),
      .reset_i (reset_i),
      .slip_i  (slip_active_o),
      .pass_i  (pass_data),
      .din_i   (din_word[lane*FRAME_SIZE +: FRAME_SIZE]),
      .dout_o  (dout_word[lane*FRAME_SIZE +: FRAME_SIZE])
    );
  end

  assign bus.sbits_o = dout_word;

endmodule : sbit_frame_tx

// File: tb/tb_sbit_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_sbit_frame_tx
// Directed bench for sbit_frame_tx: training sequence, slip windows, reslip,
// SoT error injection, enable drop, counter saturation and, when built with
// SBIT_TX_PRBS_EN, the PRBS-7 source against an independent bit recurrence.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sbit_frame_tx;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [2:0]  slip_i;
  logic [11:0] train_cycles_i;
  logic        inject_sot_err_i;
  logic        prbs_sel_i;
  logic        running_o;
  logic [2:0]  slip_active_o;
  logic [15:0] sot_err_cnt_o;

  int checks = 0;
  int errors = 0;

  sbit_frame_tx_if #(.FRAME_SIZE(8)) bus ();

  sbit_frame_tx dut (
    .clock            (clock),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .slip_i           (slip_i),
    .train_cycles_i   (train_cycles_i),
    .inject_sot_err_i (inject_sot_err_i),
    .prbs_sel_i       (prbs_sel_i),
    .bus              (bus),
    .running_o        (running_o),
    .slip_active_o    (slip_active_o),
    .sot_err_cnt_o    (sot_err_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the three outputs that define a state's framing.
  task automatic check_frame(input string tag, input logic [63:0] exp_data,
                             input logic [7:0] exp_sof, input logic exp_run);
    check({tag, " data"}, bus.sbits_o, exp_data);
    check({tag, " sof"}, 64'(bus.start_of_frame_o), 64'(exp_sof));
    check({tag, " running"}, 64'(running_o), 64'(exp_run));
  endtask

`ifdef SBIT_TX_PRBS_EN
  // Reference stream: b[n] = b[n-7] ^ b[n-6], preceded by seven ones.
  bit prbs_hist[$];

  function automatic logic [63:0] next_prbs_word();
    logic [63:0] w;
    for (int i = 0; i < 64; i++) begin
      bit b;
      b = prbs_hist[prbs_hist.size()-7] ^ prbs_hist[prbs_hist.size()-6];
      prbs_hist.push_back(b);
      w[i] = b;
    end
    return w;
  endfunction
`endif

  initial begin
    reset_i          = 1'b1;
    enable_i         = 1'b0;
    slip_i           = 3'd0;
    train_cycles_i   = 12'd4;
    inject_sot_err_i = 1'b0;
    prbs_sel_i       = 1'b0;
    bus.sbits_i      = '0;

    // Reset state.
    tick();
    tick();
    check_frame("reset", 64'h0, 8'h00, 1'b0);
    check("reset slip", 64'(slip_active_o), 64'd0);
    check("reset errcnt", 64'(sot_err_cnt_o), 64'd0);

    // Train with slip 0, train_cycles 4: five TRAIN cycles, SoT bit 7.
    reset_i  = 1'b0;
    enable_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_frame($sformatf("train%0d", c), 64'h0, 8'h80, 1'b0);
    end
    check("train slip", 64'(slip_active_o), 64'd0);

    // Sixth cycle is RUN; input was zero during training.
    tick();
    check_frame("run first", 64'h0, 8'h80, 1'b1);

    // Slip 0: output is the input one cycle later.
    bus.sbits_i = 64'h0123456789ABCDEF;
    tick();
    check_frame("slip0 word a", 64'h0123456789ABCDEF, 8'h80, 1'b1);
    bus.sbits_i = 64'hFEDCBA9876543210;
    tick();
    check_frame("slip0 word b", 64'hFEDCBA9876543210, 8'h80, 1'b1);

    // Slip 0 -> 3: one RESLIP cycle, then TRAIN with SoT bit 2.
    train_cycles_i = 12'd0;
    slip_i         = 3'd3;
    tick();
    check_frame("reslip3", 64'h0, 8'h00, 1'b0);
    check("reslip3 old slip", 64'(slip_active_o), 64'd0);
    tick();
    check_frame("train slip3", 64'h0, 8'h04, 1'b0);
    check("slip3 latched", 64'(slip_active_o), 64'd3);

    // prev = F0, din = 0F per lane: ({0F,F0} >> 5)[7:0] = 7F.
    bus.sbits_i = {8{8'hF0}};
    tick();
    check("slip3 run", 64'(running_o), 64'd1);
    bus.sbits_i = {8{8'h0F}};
    tick();
    check_frame("slip3 window", {8{8'h7F}}, 8'h04, 1'b1);

    // Slip 3 -> 5 in RUN: exactly one zero cycle, then SoT bit 4.
    slip_i = 3'd5;
    tick();
    check_frame("reslip5", 64'h0, 8'h00, 1'b0);
    tick();
    check_frame("train slip5", 64'h0, 8'h10, 1'b0);
    check("slip5 latched", 64'(slip_active_o), 64'd5);
    bus.sbits_i = {8{8'hA5}};
    tick();
    check("slip5 run", 64'(running_o), 64'd1);

    // Three inject pulses in RUN. Data {A5,A5} >> 3 keeps B4 per lane.
    for (int p = 1; p <= 3; p++) begin
      inject_sot_err_i = 1'b1;
      tick();
      check_frame($sformatf("inject%0d", p), {8{8'hB4}}, 8'h00, 1'b1);
      check($sformatf("inject%0d count", p), 64'(sot_err_cnt_o), 64'(p));
      inject_sot_err_i = 1'b0;
      tick();
      check_frame($sformatf("after inject%0d", p), {8{8'hB4}}, 8'h10, 1'b1);
    end

    // Slip change together with inject: RESLIP wins, nothing counted.
    train_cycles_i   = 12'd3;
    slip_i           = 3'd2;
    inject_sot_err_i = 1'b1;
    tick();
    check_frame("reslip2 with inject", 64'h0, 8'h00, 1'b0);
    check("reslip2 count", 64'(sot_err_cnt_o), 64'd3);
    inject_sot_err_i = 1'b0;
    tick();
    check_frame("train slip2", 64'h0, 8'h02, 1'b0);
    check("slip2 latched", 64'(slip_active_o), 64'd2);

    // Inject during TRAIN is ignored.
    inject_sot_err_i = 1'b1;
    tick();
    check_frame("train inject", 64'h0, 8'h02, 1'b0);
    check("train inject count", 64'(sot_err_cnt_o), 64'd3);
    inject_sot_err_i = 1'b0;
    tick();
    tick();
    check("train4 running", 64'(running_o), 64'd0);
    tick();
    check("slip2 run", 64'(running_o), 64'd1);

    // Enable drop with inject in the same cycle: IDLE, count unchanged.
    enable_i         = 1'b0;
    inject_sot_err_i = 1'b1;
    tick();
    check_frame("disable", 64'h0, 8'h00, 1'b0);
    check("disable count", 64'(sot_err_cnt_o), 64'd3);
    inject_sot_err_i = 1'b0;
    tick();
    check_frame("idle hold", 64'h0, 8'h00, 1'b0);

    // Re-enable with slip 7: SoT bit (7+7) mod 8 = 6.
    enable_i       = 1'b1;
    slip_i         = 3'd7;
    train_cycles_i = 12'd0;
    tick();
    check_frame("train slip7", 64'h0, 8'h40, 1'b0);
    check("slip7 latched", 64'(slip_active_o), 64'd7);
    tick();
    check("slip7 run", 64'(running_o), 64'd1);

    // Hold inject high long enough to saturate the counter.
    inject_sot_err_i = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check("saturate count", 64'(sot_err_cnt_o), 64'hFFFF);
    check("saturate sof", 64'(bus.start_of_frame_o), 64'h0);
    inject_sot_err_i = 1'b0;
    tick();
    check("saturate hold", 64'(sot_err_cnt_o), 64'hFFFF);
    check("sof restored", 64'(bus.start_of_frame_o), 64'h40);

`ifdef SBIT_TX_PRBS_EN
    // PRBS source, slip 0: first RUN word is the first chunk from the seed.
    reset_i = 1'b1;
    enable_i = 1'b0;
    tick();
    reset_i        = 1'b0;
    enable_i       = 1'b1;
    slip_i         = 3'd0;
    train_cycles_i = 12'd0;
    prbs_sel_i     = 1'b1;
    for (int i = 0; i < 7; i++) prbs_hist.push_back(1'b1);
    tick();
    check("prbs train sof", 64'(bus.start_of_frame_o), 64'h80);
    tick();
    check("prbs first word", bus.sbits_o, next_prbs_word());
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] exp_w;
      exp_w = next_prbs_word();
      tick();
      check($sformatf("prbs word %0d", i + 1), bus.sbits_o, exp_w);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sbit_frame_tx

// File: doc/sbit_frame_tx.md
Name: sbit_frame_tx

Overview:
- Transmit-side counterpart of the trigger-link frame aligner.
- Takes 64 S-bits per 40 MHz cycle and emits them as 8 lanes of FRAME_SIZE-bit frames, plus a one-hot start-of-frame word.
- Applies a programmable bit phase (slip) so the receive aligner can be exercised at any offset.
- Sits in the loopback / VFAT-emulation path and runs a train-then-run sequence with SoT error injection.

Parameters:
- FRAME_SIZE, 8, bits per frame per lane.
- MXSBITS, 8*FRAME_SIZE, total S-bits per clock.
- SOT_OFFSET, 7, added (mod FRAME_SIZE) to slip to form the SoT bit index. The default matches the aligner map "SoT bit k -> bitslip count k+1", so the receiver recovers count = slip.

Ports:
- clock  in  1  40 MHz fabric clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  transmitter enable; low forces IDLE.
- slip_i  in  3  requested bit phase, 0..FRAME_SIZE-1.
- train_cycles_i  in  12  number of TRAIN cycles before RUN.
- inject_sot_err_i  in  1  single-cycle pulse; blanks SoT for one cycle in RUN.
- prbs_sel_i  in  1  select internal PRBS data (only with SBIT_TX_PRBS_EN).
- sbits_i  in  MXSBITS  S-bits to transmit; lane I = sbits_i[8*(I+1)-1:8*I].
- sbits_o  out  MXSBITS  framed, phase-shifted S-bits.
- start_of_frame_o  out  FRAME_SIZE  one-hot SoT word.
- running_o  out  1  high in RUN.
- slip_active_o  out  3  slip currently applied.
- sot_err_cnt_o  out  16  count of injected SoT errors, saturating.

Behaviour:
- Reset (reset_i high at a clock edge):
  - state = IDLE; all outputs 0; internal previous-word registers 0; train counter 0; sot_err_cnt_o = 0.
- States and transitions:
  - IDLE: sbits_o = 0 and start_of_frame_o = 0. When enable_i = 1, latch slip_i into slip_active_o and go to TRAIN.
  - TRAIN: sbits_o = 0; SoT is valid. The counter increments each cycle. When count == train_cycles_i, go to RUN; train_cycles_i = 0 means a single TRAIN cycle.
  - RUN: data passes through; SoT is valid; running_o = 1.
  - RESLIP: entered from RUN or TRAIN when slip_i != slip_active_o. Lasts exactly one cycle with start_of_frame_o = 0 and sbits_o = 0. It then latches the new slip and returns to TRAIN with the counter cleared.
  - enable_i = 0 in any state returns to IDLE on the next edge; this takes priority over RESLIP.
- Valid SoT: start_of_frame_o = 1 << ((slip_active_o + SOT_OFFSET) mod FRAME_SIZE), registered.
- Data path, per lane:
  - prev <= din every cycle, including in TRAIN, so the first RUN word carries correct history.
  - dout = ({din, prev} >> (FRAME_SIZE - slip_active_o))[FRAME_SIZE-1:0], registered.
  - slip 0 gives dout = din delayed by 1 cycle.
- Latency:
  - sbits_o at cycle n+1 depends on sbits_i at n and n-1.
  - start_of_frame_o is aligned to sbits_o (same register stage).
- Error injection:
  - inject_sot_err_i = 1 in RUN forces start_of_frame_o = 0 for the next output cycle; data is unaffected.
  - sot_err_cnt_o increments and saturates at 16'hFFFF.
  - Injection in IDLE, TRAIN or RESLIP is ignored and not counted.
- Simultaneous events:
  - Priority order: reset_i > enable_i low > slip change > inject.
  - If a slip change and inject arrive in the same RUN cycle, RESLIP is taken and the inject is not counted.
- slip_i values ≥ FRAME_SIZE (only possible when FRAME_SIZE < 8) are taken mod FRAME_SIZE.

Optional Feature:
- Macro: SBIT_TX_PRBS_EN.
- Defined:
  - Instantiates a PRBS-7 generator (x^7+x^6+1, seed 7'h7F, reset to seed) advancing MXSBITS bits per clock.
  - When prbs_sel_i = 1, PRBS output replaces sbits_i at the data-path input.
  - The generator runs only in RUN and holds otherwise.
- Undefined: prbs_sel_i is ignored and sbits_i is always the source.

Decomposition:
- Shared package: FRAME_SIZE and SOT_OFFSET defaults; state encoding (IDLE, TRAIN, RUN, RESLIP); PRBS-7 polynomial and seed constants.
- One sub-module, frame_slip_tx: a per-lane prev register plus the rotator, instantiated 8 times with a shared slip and clock.
- The FSM, SoT generation and error counter stay in the top module.

Test Plan:
- Reset then enable=1, slip=0, train_cycles=4:
  - 5 TRAIN cycles with sbits_o = 0 and SoT = 8'h80.
  - running_o rises on the 6th cycle.
  - sbits_i = 64'h0123456789ABCDEF appears on sbits_o one cycle later.
- slip=3, lane 0 with prev 8'hF0 then din 8'h0F:
  - lane 0 out = ({8'h0F, 8'hF0} >> 5)[7:0] = 8'h7F (bits 12..5 of 16'h0FF0).
  - SoT = 8'h04.
- Change slip 3->5 in RUN:
  - exactly one cycle of SoT = 0 and data = 0.
  - TRAIN restarts; SoT = 8'h10; slip_active_o = 5.
- Three inject pulses in RUN, one in TRAIN:
  - three single-cycle SoT = 0 gaps; sot_err_cnt_o = 3.
- enable_i dropped in the same cycle as an inject:
  - next cycle IDLE with all outputs 0; count unchanged.
- With SBIT_TX_PRBS_EN, prbs_sel=1, slip=0:
  - the first RUN word equals the first 64-bit PRBS-7 chunk from seed 7'h7F.
  - the reference model matches over 1000 cycles.
